// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with status flags and a saturating delivered-op counter.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err,
  output logic [CNT_W-1:0] op_count
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ILL
  } op_e;
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             s2_free, s1_adv, in_xfer, out_xfer;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum, diff, shl, shr;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d, err_d;
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  // Shifts run one bit wider so the last bit shifted out lands in the extra bit; amount 0 leaves it 0.
  always_comb begin
    sh    = b_q[SW-1:0];
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    shl   = {1'b0, a_q} << sh;
    shr   = {a_q, 1'b0} >> sh;
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff[WIDTH-1:0];
        c_d   = diff[WIDTH];
        v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SHL: begin
        res_d = shl[WIDTH-1:0];
        c_d   = shl[WIDTH];
      end
      OP_SHR: begin
        res_d = shr[WIDTH:1];
        c_d   = shr[0];
      end
      OP_ILL: err_d = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      out_valid  <= 1'b0;
      alu_result <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      flag_err   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_xfer) begin
        a_q  <= data_a;
        b_q  <= data_b;
        op_q <= op_e'(alu_op);
      end
      if (s2_free) out_valid <= s1_valid_q;
      if (s1_adv) begin
        alu_result <= res_d;
        flag_z     <= res_d == '0;
        flag_n     <= res_d[WIDTH-1];
        flag_c     <= c_d;
        flag_v     <= v_d;
        flag_err   <= err_d;
      end
      if (out_xfer && !(&op_count)) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic [2:0] alu_op = '0;
  logic       in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, flag_err;
  logic [7:0] alu_result;
  logic [15:0] op_count;
  logic       in_ready4, out_valid4, z4, n4, c4, v4, e4;
  logic [7:0] res4;
  logic [3:0] op_count4;
  int n_chk = 0, n_pass = 0;
  logic [12:0] exp_q[$];

  alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .flag_err(flag_err), .op_count(op_count));

  alu_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .data_a(data_a), .data_b(data_b), .alu_op(alu_op), .out_valid(out_valid4),
    .out_ready(out_ready), .alu_result(res4), .flag_z(z4), .flag_n(n4),
    .flag_c(c4), .flag_v(v4), .flag_err(e4), .op_count(op_count4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns {err, v, c, n, z, result[7:0]} using signed/unsigned integer arithmetic.
  function automatic logic [12:0] model(input int a, input int b, input int op);
    int r, c, v, err, sa, sb, sh;
    logic [7:0] r8;
    r = 0; c = 0; v = 0; err = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    case (op)
      0: begin r = (a + b) % 256; c = int'(a + b > 255); v = int'(sa + sb > 127 || sa + sb < -128); end
      1: begin r = (a - b + 256) % 256; c = int'(a < b); v = int'(sa - sb > 127 || sa - sb < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) % 256; c = (sh != 0) ? (a >> (8 - sh)) & 1 : 0; end
      6: begin r = a >> sh; c = (sh != 0) ? (a >> (sh - 1)) & 1 : 0; end
      default: err = 1;
    endcase
    r8 = r[7:0];
    return {err[0], v[0], c[0], int'(r >= 128) != 0, r == 0, r8};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
        else chk("model", 32'({flag_err, flag_v, flag_c, flag_n, flag_z, alu_result}), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(data_a), int'(data_b), int'(alu_op)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic dir(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                     input logic [7:0] er, input logic [4:0] ef);
    in_valid = 1'b1;
    data_a = a;
    data_b = b;
    alu_op = op;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk(tag, 32'({flag_err, flag_v, flag_c, flag_n, flag_z, alu_result}), 32'({ef, er}));
  endtask

  initial begin
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_result_flags", 32'({flag_err, flag_v, flag_c, flag_n, flag_z, alu_result}), 0);
    chk("rst_count", 32'(op_count), 0);
    out_ready = 1'b1;
    dir("add_ff_01", 8'hFF, 8'h01, 3'd0, 8'h00, 5'b00101);
    dir("add_7f_01", 8'h7F, 8'h01, 3'd0, 8'h80, 5'b01010);
    dir("sub_80_01", 8'h80, 8'h01, 3'd1, 8'h7F, 5'b01000);
    dir("sub_01_02", 8'h01, 8'h02, 3'd1, 8'hFF, 5'b00110);
    dir("shl_81_1",  8'h81, 8'h01, 3'd5, 8'h02, 5'b00100);
    dir("shr_81_3",  8'h81, 8'h03, 3'd6, 8'h10, 5'b00000);
    dir("shl_amt0",  8'h81, 8'h08, 3'd5, 8'h81, 5'b00010);
    dir("illegal",   8'h55, 8'hAA, 3'd7, 8'h00, 5'b10001);
    dir("and_after", 8'h0F, 8'h3C, 3'd2, 8'h0C, 5'b00000);
    tick();
    // Backpressure: two ops fill the pipe, the third waits.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    data_a = 8'h01; data_b = 8'h02; alu_op = 3'd0;
    chk("bp_rdy1", 32'(in_ready), 1);
    tick();
    data_a = 8'h05; data_b = 8'h01; alu_op = 3'd1;
    chk("bp_rdy2", 32'(in_ready), 1);
    tick();
    data_a = 8'hF0; data_b = 8'h0F; alu_op = 3'd4;
    chk("bp_rdy3", 32'(in_ready), 0);
    chk("bp_r1", 32'(alu_result), 32'h03);
    tick();
    chk("bp_hold_r1", 32'(alu_result), 32'h03);
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_rdy", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_r2", 32'(alu_result), 32'h04);
    tick();
    chk("bp_r3", 32'(alu_result), 32'hFF);
    chk("bp_r3_valid", 32'(out_valid), 1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);
    chk("bp_count", 32'(op_count), 3);
    // Streaming: 100 random back-to-back ops.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      alu_op = 3'($urandom_range(0, 7));
      tick();
    end
    chk("stream_no_bubble", 32'(op_count), 98);
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_count", 32'(op_count), 100);
    chk("stream_sat4", 32'(op_count4), 15);
    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    data_a = 8'h11; data_b = 8'h22; alu_op = 3'd3;
    tick();
    data_a = 8'h33; data_b = 8'h44; alu_op = 3'd0;
    tick();
    in_valid = 1'b0;
    chk("mid_full_rdy", 32'(in_ready), 0);
    rst_n = 1'b0;
    tick();
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_count", 32'(op_count), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    chk("mid_result_flags", 32'({flag_err, flag_v, flag_c, flag_n, flag_z, alu_result}), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 0);
    end
    chk("drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
